// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : RISC-V instruction decode with a two-entry (main + skid) buffer.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter int XLEN         = 32,
  parameter bit RV64_OP32_EN = 1'b0,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [5:0]       out_type,
  output logic             out_rs1_used,
  output logic             out_rs2_used,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] dec_count
);

  // The 32-bit word forms are only meaningful on an RV64 datapath
  localparam logic c_op32_en = (XLEN == 64) && RV64_OP32_EN;

  localparam logic [6:0] c_op_op       = 7'b0110011;
  localparam logic [6:0] c_op_op32     = 7'b0111011;
  localparam logic [6:0] c_op_imm      = 7'b0010011;
  localparam logic [6:0] c_op_imm32    = 7'b0011011;
  localparam logic [6:0] c_op_load     = 7'b0000011;
  localparam logic [6:0] c_op_jalr     = 7'b1100111;
  localparam logic [6:0] c_op_fence    = 7'b0001111;
  localparam logic [6:0] c_op_system   = 7'b1110011;
  localparam logic [6:0] c_op_store    = 7'b0100011;
  localparam logic [6:0] c_op_branch   = 7'b1100011;
  localparam logic [6:0] c_op_lui      = 7'b0110111;
  localparam logic [6:0] c_op_auipc    = 7'b0010111;
  localparam logic [6:0] c_op_jal      = 7'b1101111;

  localparam logic [5:0] c_t_r = 6'b000001;
  localparam logic [5:0] c_t_i = 6'b000010;
  localparam logic [5:0] c_t_s = 6'b000100;
  localparam logic [5:0] c_t_b = 6'b001000;
  localparam logic [5:0] c_t_u = 6'b010000;
  localparam logic [5:0] c_t_j = 6'b100000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [5:0]      itype;
    logic            rs1_used;
    logic            rs2_used;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } bundle_t;

  logic [5:0]      w_type;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_rs1_used;
  logic            w_rs2_used;
  logic            w_illegal;
  logic            w_accept;
  bundle_t         w_dec;

  bundle_t          r_main;
  bundle_t          r_skid;
  logic             r_main_valid;
  logic             r_skid_valid;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    w_type = '0;
    case (in_inst[6:0])
      c_op_op:     w_type = c_t_r;
      c_op_op32:   w_type = c_op32_en ? c_t_r : 6'b000000;
      c_op_imm,
      c_op_load,
      c_op_jalr,
      c_op_fence,
      c_op_system: w_type = c_t_i;
      c_op_imm32:  w_type = c_op32_en ? c_t_i : 6'b000000;
      c_op_store:  w_type = c_t_s;
      c_op_branch: w_type = c_t_b;
      c_op_lui,
      c_op_auipc:  w_type = c_t_u;
      c_op_jal:    w_type = c_t_j;
      default:     w_type = '0;
    endcase
    if (in_inst[1:0] != 2'b11) begin
      w_type = '0;
    end
  end

  always_comb begin
    w_imm32    = '0;
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    case (w_type)
      c_t_r: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
      end
      c_t_i: begin
        w_imm32    = {{20{in_inst[31]}}, in_inst[31:20]};
        w_rs1_used = 1'b1;
      end
      c_t_s: begin
        w_imm32    = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
      end
      c_t_b: begin
        w_imm32    = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
      end
      c_t_u:   w_imm32 = {in_inst[31:12], 12'h000};
      c_t_j:   w_imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign w_illegal = (w_type == 6'b000000);

  generate
    if (XLEN == 64) begin : g_imm64
      assign w_imm = {{32{w_imm32[31]}}, w_imm32};
    end else begin : g_imm32
      assign w_imm = w_imm32;
    end
  endgenerate

  always_comb begin
    w_dec          = '0;
    w_dec.pc       = in_pc;
    w_dec.rs1      = in_inst[19:15];
    w_dec.rs2      = in_inst[24:20];
    w_dec.rd       = in_inst[11:7];
    w_dec.opcode   = in_inst[6:0];
    w_dec.funct3   = in_inst[14:12];
    w_dec.funct7   = in_inst[31:25];
    w_dec.itype    = w_type;
    w_dec.rs1_used = w_rs1_used;
    w_dec.rs2_used = w_rs2_used;
    w_dec.imm      = w_imm;
    w_dec.illegal  = w_illegal;
  end

  assign w_accept = in_valid && r_in_ready;

  // r_in_ready always tracks !r_skid_valid so the handshake is register-driven
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (r_skid_valid) begin
      if (out_ready) begin
        r_main       <= r_skid;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end
    end else if (w_accept) begin
      if (!r_main_valid || out_ready) begin
        r_main       <= w_dec;
        r_main_valid <= 1'b1;
      end else begin
        r_skid       <= w_dec;
        r_skid_valid <= 1'b1;
        r_in_ready   <= 1'b0;
      end
    end else if (out_ready) begin
      r_main_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_main_valid && out_ready && !r_main.illegal && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_main_valid;
  assign out_pc       = r_main.pc;
  assign out_rs1      = r_main.rs1;
  assign out_rs2      = r_main.rs2;
  assign out_rd       = r_main.rd;
  assign out_opcode   = r_main.opcode;
  assign out_funct3   = r_main.funct3;
  assign out_funct7   = r_main.funct7;
  assign out_type     = r_main.itype;
  assign out_rs1_used = r_main.rs1_used;
  assign out_rs2_used = r_main.rs2_used;
  assign out_imm      = r_main.imm;
  assign out_illegal  = r_main.illegal;
  assign dec_count    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Table-driven, scoreboarded bench for decode_stage (RV64 + OP-32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      in_inst = '0;
  logic [XLEN-1:0]  in_pc = '0;
  logic             in_ready;
  logic             out_valid;
  logic [XLEN-1:0]  out_pc;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic [6:0]       out_opcode;
  logic [2:0]       out_funct3;
  logic [6:0]       out_funct7;
  logic [5:0]       out_type;
  logic             out_rs1_used;
  logic             out_rs2_used;
  logic [XLEN-1:0]  out_imm;
  logic             out_illegal;
  logic [CNT_W-1:0] dec_count;

  decode_stage #(.XLEN(XLEN), .RV64_OP32_EN(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_type(out_type), .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used),
    .out_imm(out_imm), .out_illegal(out_illegal), .dec_count(dec_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [5:0]  typ;
    logic [63:0] imm;
    logic        rs1u;
    logic        rs2u;
    logic        ill;
  } vec_t;

  typedef struct packed {
    vec_t        v;
    logic [63:0] pc;
  } exp_t;

  vec_t             vecs[15];
  exp_t             sb[$];
  exp_t             cur;
  int               errors = 0;
  int               checks = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on delivery, track the counter
  always @(negedge clk) begin
    exp_t         e;
    logic [168:0] act;
    logic [168:0] expv;
    if (rst) begin
      sb.delete();
      exp_cnt = '0;
    end else begin
      chk("dec_count", 64'(dec_count), 64'(exp_cnt));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bundle: got pc %h expected none", out_pc);
        end else begin
          e    = sb.pop_front();
          act  = {out_pc, out_rs1, out_rs2, out_rd, out_opcode, out_funct3, out_funct7,
                  out_type, out_rs1_used, out_rs2_used, out_imm, out_illegal};
          expv = {e.pc, e.v.inst[19:15], e.v.inst[24:20], e.v.inst[11:7], e.v.inst[6:0],
                  e.v.inst[14:12], e.v.inst[31:25], e.v.typ, e.v.rs1u, e.v.rs2u,
                  e.v.imm, e.v.ill};
          checks++;
          if (act !== expv) begin
            errors++;
            $display("FAIL bundle pc=%h: got %h expected %h", e.pc, act, expv);
          end
          if (!e.v.ill && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(cur);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input logic [63:0] pc);
    in_valid = 1'b1;
    in_inst  = vecs[idx].inst;
    in_pc    = pc;
    cur.v    = vecs[idx];
    cur.pc   = pc;
  endtask

  task automatic wait_accept(input bit rnd);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        step();
        in_valid = 1'b0;
        return;
      end
      step();
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    in_valid = 1'b0;
  endtask

  task automatic send(input int idx, input logic [63:0] pc, input bit rnd);
    drive(idx, pc);
    wait_accept(rnd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'hFFF00093, 6'b000010, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0}; // ADDI x1,x0,-1
    vecs[1]  = '{32'h00000463, 6'b001000, 64'h8,                   1'b1, 1'b1, 1'b0}; // BEQ +8
    vecs[2]  = '{32'h00000000, 6'b000000, 64'h0,                   1'b0, 1'b0, 1'b1};
    vecs[3]  = '{32'h800002B7, 6'b010000, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0, 1'b0}; // LUI
    vecs[4]  = '{32'h0010809B, 6'b000010, 64'h1,                   1'b1, 1'b0, 1'b0}; // ADDIW
    vecs[5]  = '{32'h002081B3, 6'b000001, 64'h0,                   1'b1, 1'b1, 1'b0}; // ADD
    vecs[6]  = '{32'h0020A423, 6'b000100, 64'h8,                   1'b1, 1'b1, 1'b0}; // SW
    vecs[7]  = '{32'hFFDFF0EF, 6'b100000, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b0}; // JAL -4
    vecs[8]  = '{32'h00001017, 6'b010000, 64'h1000,                1'b0, 1'b0, 1'b0}; // AUIPC
    vecs[9]  = '{32'h00000090, 6'b000000, 64'h0,                   1'b0, 1'b0, 1'b1}; // bad low bits
    vecs[10] = '{32'h002081BB, 6'b000001, 64'h0,                   1'b1, 1'b1, 1'b0}; // ADDW
    vecs[11] = '{32'hFF812283, 6'b000010, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b0, 1'b0}; // LW -8
    vecs[12] = '{32'h00000073, 6'b000010, 64'h0,                   1'b1, 1'b0, 1'b0}; // ECALL
    vecs[13] = '{32'h0000007F, 6'b000000, 64'h0,                   1'b0, 1'b0, 1'b1};
    vecs[14] = '{32'h0FF0000F, 6'b000010, 64'hFF,                  1'b1, 1'b0, 1'b0}; // FENCE

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_dec_count", 64'(dec_count), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_imm", out_imm, 64'd0);
    chk("rst_out_type", 64'(out_type), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // ADDI x1,x0,-1 with one-cycle latency
    out_ready = 1'b1;
    drive(0, 64'h1000);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_type", 64'(out_type), 64'h2);
    chk("addi_rd", 64'(out_rd), 64'd1);
    chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_rs1_used", 64'(out_rs1_used), 64'd1);
    chk("addi_rs2_used", 64'(out_rs2_used), 64'd0);
    step();
    @(negedge clk);
    chk("addi_count", 64'(dec_count), 64'd1);
    step();

    // Table pass 1: streaming, pass 2: random back-pressure
    for (int i = 0; i < 15; i++) send(i, 64'h2000 + 64'(4 * i), 1'b0);
    for (int i = 0; i < 15; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      send(i, 64'h3000 + 64'(4 * i), 1'b1);
    end
    out_ready = 1'b1;
    repeat (5) step();
    chk("drain_table", 64'(sb.size()), 64'd0);
    chk("dec_count_sat", 64'(dec_count), 64'hF);

    // Stall with skid full: outputs frozen, order preserved
    out_ready = 1'b0;
    drive(1, 64'h100);
    step();
    drive(0, 64'h104);
    step();
    drive(5, 64'h108);
    @(negedge clk);
    chk("skid_in_ready", 64'(in_ready), 64'd0);
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_pc", out_pc, 64'h100);
    chk("stall_opcode", 64'(out_opcode), 64'h63);
    step();
    @(negedge clk);
    chk("frozen_pc", out_pc, 64'h100);
    chk("frozen_imm", out_imm, 64'h8);
    chk("frozen_in_ready", 64'(in_ready), 64'd0);
    step();
    out_ready = 1'b1;
    wait_accept(1'b0);
    repeat (4) step();
    chk("drain_stall", 64'(sb.size()), 64'd0);

    // Flush with both entries full and a word on the input
    out_ready = 1'b0;
    drive(6, 64'h200);
    step();
    drive(7, 64'h204);
    step();
    drive(8, 64'h208);
    @(negedge clk);
    chk("pre_flush_in_ready", 64'(in_ready), 64'd0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    repeat (3) step();

    // Asynchronous reset with a bundle held
    out_ready = 1'b0;
    drive(0, 64'h300);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_count", 64'(dec_count), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    chk("async_rst_pc", out_pc, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // First transfer after reset behaves as from empty
    out_ready = 1'b1;
    send(6, 64'h400, 1'b0);
    repeat (3) step();
    chk("post_rst_count", 64'(dec_count), 64'd1);
    chk("post_rst_drain", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
